cv_sp_fetch: RTL and testbench
==============================

CV_SP_FETCH -- requirements
Module: cv_sp_fetch

Interface
REQ-001 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous, active-high.
REQ-002 SHALL have cs in 1: line-fetch enable; low forces idle.
REQ-003 SHALL have v_count in 10: current display line; search_end in 1: scan list complete; search_count in 11: number of valid scan-list entries.
REQ-004 SHALL have sch_addr out 10, sch_ren out 1, sch_din in 10: scan-list read port, data valid one cycle after sch_ren.
REQ-005 SHALL have p_addr out 10, p_ren out 1, p_din in 64: sprite attribute read port, one-cycle latency.
REQ-006 SHALL have pat_addr out 14, pat_ren out 1, pat_din in 16: pattern row read port, one-cycle latency.
REQ-007 SHALL have lb_addr out 10, lb_wen out 1, lb_wrdata out 4: line-buffer write port.
REQ-008 SHALL have fetch_end out 1: line done; sp_overflow out 1: more hits than limit.

Function
REQ-009 Attribute fields SHALL be: Y=p_din[10:0], X=p_din[25:16], PAT=p_din[41:32], COLOR=p_din[51:48]; other bits ignored.
REQ-010 States SHALL be IDLE, RD_SCH, RD_ATTR, RD_PAT, LOAD, DRAW, DONE; 11-bit entry index idx, 4-bit pixel counter px.
REQ-011 cs=0 in any state SHALL force IDLE next cycle, clear idx, px, sp_overflow; all port outputs 0 while in IDLE.
REQ-012 IDLE with cs=1 and search_end=1: latch effective count N; N=0 -> DONE, else RD_SCH with idx=0.
REQ-013 RD_SCH: sch_ren=1, sch_addr=idx[9:0]; next RD_ATTR.
REQ-014 RD_ATTR: p_ren=1, p_addr=sch_din (combinational); next RD_PAT.
REQ-015 RD_PAT: pat_ren=1, pat_addr={PAT, row}, row=(({1'b0,v_count}-Y) mod 2048)[3:0]; register X and COLOR; next LOAD.
REQ-016 LOAD: register pat_din into 16-bit pattern reg; px=0; next DRAW.
REQ-017 DRAW: 16 cycles, px 0..15; pixel bit = pattern[15-px] (MSB leftmost); s = X+px in 11 bits.
REQ-018 DRAW: lb_wen=1 iff bit=1 and s<1024; lb_addr=s[9:0]; lb_wrdata=COLOR; transparent or off-line pixels not written.
REQ-019 After px=15: idx<=idx+1; idx+1=N -> DONE, else RD_SCH.
REQ-020 Per-sprite cost SHALL be exactly 20 cycles; entries drawn in ascending idx, later writes overwrite earlier (higher idx wins).
REQ-021 DONE: fetch_end=1, all read/write enables 0; hold until cs=0.
REQ-022 search_end ignored outside IDLE; v_count assumed stable while not IDLE.

Reset
REQ-023 reset=1 SHALL asynchronously set state IDLE, idx=0, px=0, pattern/X/COLOR regs 0, sp_overflow=0; all outputs 0.
REQ-024 Reset mid-DRAW SHALL abort with no further lb_wen after reset asserts.

Configuration
REQ-025 Macro CV_SP_FETCH_LIMIT_EN defined: N=min(search_count,16); sp_overflow registered 1 at latch if search_count>16, held until IDLE.
REQ-026 Macro undefined: N=search_count (0..1024); sp_overflow constant 0.

Verification
REQ-027 search_count=0, search_end pulse -> DONE next cycle, fetch_end=1, no sch_ren/p_ren/pat_ren/lb_wen.
REQ-028 One entry sch=5, attr Y=100 X=200 PAT=3 COLOR=7, v_count=104, pat_din=16'h8001 -> p_addr=5, pat_addr={3,4'd4}; lb_wen at addr 200 and 215 only, data 7; fetch_end 20 cycles after RD_SCH entry.
REQ-029 X=1020, pat_din=16'hFFFF -> writes addrs 1020..1023 only, 12 pixels suppressed.
REQ-030 Two entries overlapping same X, colors 2 then 9 -> final writes show 9 last at shared addresses.
REQ-031 LIMIT_EN, search_count=20 -> exactly 16 sprites (320 cycles), sp_overflow=1; without macro 20 sprites, sp_overflow=0.
REQ-032 cs dropped during DRAW px=6 -> IDLE next cycle, lb_wen=0, later cs/search_end restarts at idx=0.

Source files
------------

// File: rtl/cv_sp_fetch_if.sv
// Memory-side bus bundle for cv_sp_fetch: scan-list, attribute and pattern read ports,
// plus the line-buffer write port.
interface cv_sp_fetch_if;
  logic [9:0]  sch_addr;
  logic        sch_ren;
  logic [9:0]  sch_din;
  logic [9:0]  p_addr;
  logic        p_ren;
  logic [63:0] p_din;
  logic [13:0] pat_addr;
  logic        pat_ren;
  logic [15:0] pat_din;
  logic [9:0]  lb_addr;
  logic        lb_wen;
  logic [3:0]  lb_wrdata;

  modport master (
    output sch_addr, sch_ren, input sch_din,
    output p_addr, p_ren, input p_din,
    output pat_addr, pat_ren, input pat_din,
    output lb_addr, lb_wen, lb_wrdata
  );

  modport slave (
    input sch_addr, sch_ren, output sch_din,
    input p_addr, p_ren, output p_din,
    input pat_addr, pat_ren, output pat_din,
    input lb_addr, lb_wen, lb_wrdata
  );
endinterface

// File: rtl/cv_sp_fetch.sv
// Sprite line fetch: walks the scan list, reads attributes and pattern rows, and paints one
// 16-pixel sprite row per entry into the line buffer. Option macro: CV_SP_FETCH_LIMIT_EN.
module cv_sp_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic [9:0]  v_count,
  input  logic        search_end,
  input  logic [10:0] search_count,
  cv_sp_fetch_if.master mem,
  output logic        fetch_end,
  output logic        sp_overflow
);

  typedef enum logic [2:0] {
    StIdle, StRdSch, StRdAttr, StRdPat, StLoad, StDraw, StDone
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [10:0] r_idx;
  logic [10:0] r_n;
  logic [3:0]  r_px;
  logic [9:0]  r_x;
  logic [3:0]  r_color;
  logic [15:0] r_pat;

  logic [10:0] w_n_eff;
  logic        w_ovf_set;
  logic [10:0] w_idx_inc;
  logic [10:0] w_diff;
  logic [10:0] w_s;
  logic        w_pix;
  logic        w_unused_bits;

  logic [9:0]  w_sch_addr, w_p_addr, w_lb_addr;
  logic        w_sch_ren, w_p_ren, w_pat_ren, w_lb_wen, w_fetch_end;
  logic [13:0] w_pat_addr;
  logic [3:0]  w_lb_wrdata;

`ifdef CV_SP_FETCH_LIMIT_EN
  assign w_n_eff   = (search_count > 11'd16) ? 11'd16 : search_count;
  assign w_ovf_set = (search_count > 11'd16);
`else
  assign w_n_eff   = search_count;
  assign w_ovf_set = 1'b0;
`endif

  assign w_idx_inc = r_idx + 11'd1;
  // Sprite row within the 16-line pattern; wraps modulo 2048 like the Y compare upstream.
  assign w_diff    = {1'b0, v_count} - mem.p_din[10:0];
  assign w_s       = {1'b0, r_x} + {7'd0, r_px};
  assign w_pix     = r_pat[4'd15 - r_px];

  assign w_unused_bits = ^{mem.p_din[63:52], mem.p_din[47:42], mem.p_din[31:26],
                           mem.p_din[15:11], w_diff[10:4]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sch_ren   = 1'b0;
    w_sch_addr  = '0;
    w_p_ren     = 1'b0;
    w_p_addr    = '0;
    w_pat_ren   = 1'b0;
    w_pat_addr  = '0;
    w_lb_wen    = 1'b0;
    w_lb_addr   = '0;
    w_lb_wrdata = '0;
    w_fetch_end = 1'b0;
    case (r_state)
      StIdle: begin
        if (search_end) begin
          w_state_nxt = (w_n_eff == 11'd0) ? StDone : StRdSch;
        end
      end
      StRdSch: begin
        w_sch_ren   = 1'b1;
        w_sch_addr  = r_idx[9:0];
        w_state_nxt = StRdAttr;
      end
      StRdAttr: begin
        w_p_ren     = 1'b1;
        w_p_addr    = mem.sch_din;
        w_state_nxt = StRdPat;
      end
      StRdPat: begin
        w_pat_ren   = 1'b1;
        w_pat_addr  = {mem.p_din[41:32], w_diff[3:0]};
        w_state_nxt = StLoad;
      end
      StLoad: begin
        w_state_nxt = StDraw;
      end
      StDraw: begin
        // Pixels landing past the right edge are dropped rather than wrapped.
        w_lb_wen    = w_pix & ~w_s[10];
        w_lb_addr   = w_s[9:0];
        w_lb_wrdata = r_color;
        if (r_px == 4'd15) begin
          w_state_nxt = (w_idx_inc == r_n) ? StDone : StRdSch;
        end
      end
      StDone: begin
        w_fetch_end = 1'b1;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    if (!cs) begin
      w_state_nxt = StIdle;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_n     <= '0;
      r_px    <= '0;
      r_x     <= '0;
      r_color <= '0;
      r_pat   <= '0;
    end else if (!cs) begin
      r_idx <= '0;
      r_px  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (search_end) begin
            r_n   <= w_n_eff;
            r_idx <= '0;
          end
        end
        StRdPat: begin
          r_x     <= mem.p_din[25:16];
          r_color <= mem.p_din[51:48];
        end
        StLoad: begin
          r_pat <= mem.pat_din;
          r_px  <= '0;
        end
        StDraw: begin
          r_px <= r_px + 4'd1;
          if (r_px == 4'd15) begin
            r_idx <= w_idx_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CV_SP_FETCH_LIMIT_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (!cs) begin
      r_ovf <= 1'b0;
    end else if (r_state == StIdle && search_end) begin
      r_ovf <= w_ovf_set;
    end
  end

  assign sp_overflow = r_ovf;
`else
  assign sp_overflow = w_ovf_set;
`endif

  assign mem.sch_addr  = w_sch_addr;
  assign mem.sch_ren   = w_sch_ren;
  assign mem.p_addr    = w_p_addr;
  assign mem.p_ren     = w_p_ren;
  assign mem.pat_addr  = w_pat_addr;
  assign mem.pat_ren   = w_pat_ren;
  assign mem.lb_addr   = w_lb_addr;
  assign mem.lb_wen    = w_lb_wen;
  assign mem.lb_wrdata = w_lb_wrdata;
  assign fetch_end     = w_fetch_end;

endmodule

// File: tb/tb_cv_sp_fetch.sv
// Directed bench for cv_sp_fetch: memory models with one-cycle read latency and a
// line-buffer monitor; each task checks one scenario against hand-computed values.
module tb_cv_sp_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [9:0]  v_count;
  logic        search_end;
  logic [10:0] search_count;
  logic        fetch_end;
  logic        sp_overflow;

  cv_sp_fetch_if u_if ();

  cv_sp_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .v_count      (v_count),
    .search_end   (search_end),
    .search_count (search_count),
    .mem          (u_if.master),
    .fetch_end    (fetch_end),
    .sp_overflow  (sp_overflow)
  );

  always #5 clk = ~clk;

  logic [9:0]  sch_mem  [1024];
  logic [63:0] attr_mem [1024];
  logic [15:0] pat_mem  [16384];

  always @(posedge clk) begin
    if (u_if.sch_ren) u_if.sch_din <= sch_mem[u_if.sch_addr];
    if (u_if.p_ren)   u_if.p_din   <= attr_mem[u_if.p_addr];
    if (u_if.pat_ren) u_if.pat_din <= pat_mem[u_if.pat_addr];
  end

  int errors = 0;
  int checks = 0;

  logic        clr = 1'b0;
  int          sch_cnt, p_cnt, pat_cnt, wr_cnt;
  logic [9:0]  first_sch, last_p_addr, last_wr_addr;
  logic [13:0] last_pat_addr;
  logic [3:0]  lb [1024];

  always @(negedge clk) begin
    if (clr) begin
      sch_cnt = 0; p_cnt = 0; pat_cnt = 0; wr_cnt = 0;
      first_sch = '1; last_p_addr = '0; last_pat_addr = '0; last_wr_addr = '0;
      for (int i = 0; i < 1024; i++) lb[i] = 4'h0;
    end else begin
      if (u_if.sch_ren) begin
        if (sch_cnt == 0) first_sch = u_if.sch_addr;
        sch_cnt++;
      end
      if (u_if.p_ren) begin
        last_p_addr = u_if.p_addr;
        p_cnt++;
      end
      if (u_if.pat_ren) begin
        last_pat_addr = u_if.pat_addr;
        pat_cnt++;
      end
      if (u_if.lb_wen) begin
        lb[u_if.lb_addr] = u_if.lb_wrdata;
        last_wr_addr = u_if.lb_addr;
        wr_cnt++;
      end
    end
  end

  function automatic logic [63:0] attr(input logic [10:0] y, input logic [9:0] x,
                                       input logic [9:0] pat, input logic [3:0] col);
    return {12'h0, col, 6'h0, pat, 6'h0, x, 5'h0, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic start_fetch();
    cs = 1'b1;
    search_end = 1'b1;
    tick();
    search_end = 1'b0;
  endtask

  // Cycles counted from the first RD_SCH cycle until fetch_end is seen.
  task automatic run_fetch(input int budget, output int cycles);
    start_fetch();
    cycles = 0;
    while (!fetch_end && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic stop_fetch();
    cs = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; cs = 1'b0; search_end = 1'b0; search_count = '0; v_count = '0;
    tick();
    tick();
    checks++;
    if ({fetch_end, sp_overflow, u_if.sch_ren, u_if.p_ren, u_if.pat_ren, u_if.lb_wen} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {fetch_end, sp_overflow, u_if.sch_ren, u_if.p_ren, u_if.pat_ren, u_if.lb_wen});
    end
    checks++;
    if ({u_if.sch_addr, u_if.p_addr, u_if.pat_addr, u_if.lb_addr, u_if.lb_wrdata} !== 48'h0) begin
      errors++;
      $display("FAIL reset_addrs: got %h want 0",
               {u_if.sch_addr, u_if.p_addr, u_if.pat_addr, u_if.lb_addr, u_if.lb_wrdata});
    end
    reset = 1'b0;
    tick();
    clear_logs();
    cs = 1'b1;
    tick();
    tick();
    checks++;
    if (sch_cnt !== 0 || fetch_end !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: sch_cnt=%0d fetch_end=%b want 0 0", sch_cnt, fetch_end);
    end
    stop_fetch();
  endtask

  task automatic test_zero_count();
    clear_logs();
    search_count = 11'd0;
    start_fetch();
    checks++;
    if (fetch_end !== 1'b1) begin
      errors++;
      $display("FAIL zero_done: fetch_end=%b want 1", fetch_end);
    end
    tick();
    tick();
    checks++;
    if (fetch_end !== 1'b1) begin
      errors++;
      $display("FAIL zero_hold: fetch_end=%b want 1", fetch_end);
    end
    checks++;
    if (sch_cnt + p_cnt + pat_cnt + wr_cnt !== 0) begin
      errors++;
      $display("FAIL zero_no_access: got %0d accesses want 0", sch_cnt + p_cnt + pat_cnt + wr_cnt);
    end
    stop_fetch();
    checks++;
    if (fetch_end !== 1'b0) begin
      errors++;
      $display("FAIL zero_release: fetch_end=%b want 0", fetch_end);
    end
  endtask

  task automatic test_single();
    int cyc;
    clear_logs();
    sch_mem[0] = 10'd5;
    attr_mem[5] = attr(11'd100, 10'd200, 10'd3, 4'd7);
    pat_mem[{10'd3, 4'd4}] = 16'h8001;
    v_count = 10'd104;
    search_count = 11'd1;
    run_fetch(1000, cyc);
    checks++;
    if (cyc !== 20) begin
      errors++;
      $display("FAIL single_cycles: got %0d want 20", cyc);
    end
    checks++;
    if (last_p_addr !== 10'd5 || p_cnt !== 1) begin
      errors++;
      $display("FAIL single_p_addr: got %0d (%0d reads) want 5 (1 read)", last_p_addr, p_cnt);
    end
    checks++;
    if (last_pat_addr !== 14'd52 || pat_cnt !== 1) begin
      errors++;
      $display("FAIL single_pat_addr: got %0d (%0d reads) want 52 (1 read)", last_pat_addr, pat_cnt);
    end
    checks++;
    if (wr_cnt !== 2 || lb[200] !== 4'd7 || lb[215] !== 4'd7 || last_wr_addr !== 10'd215) begin
      errors++;
      $display("FAIL single_writes: cnt=%0d lb200=%0d lb215=%0d last=%0d want 2 7 7 215",
               wr_cnt, lb[200], lb[215], last_wr_addr);
    end
    stop_fetch();
  endtask

  task automatic test_clip();
    int cyc;
    clear_logs();
    sch_mem[0] = 10'd8;
    attr_mem[8] = attr(11'd50, 10'd1020, 10'd5, 4'd3);
    pat_mem[{10'd5, 4'd2}] = 16'hFFFF;
    v_count = 10'd52;
    search_count = 11'd1;
    run_fetch(1000, cyc);
    checks++;
    if (wr_cnt !== 4 || last_wr_addr !== 10'd1023) begin
      errors++;
      $display("FAIL clip_count: cnt=%0d last=%0d want 4 1023", wr_cnt, last_wr_addr);
    end
    checks++;
    if ({lb[1020], lb[1021], lb[1022], lb[1023]} !== 16'h3333 || lb[0] !== 4'h0) begin
      errors++;
      $display("FAIL clip_data: got %h lb0=%h want 3333 0",
               {lb[1020], lb[1021], lb[1022], lb[1023]}, lb[0]);
    end
    stop_fetch();
  endtask

  task automatic test_back_to_back();
    int cyc;
    clear_logs();
    sch_mem[0] = 10'd10;
    sch_mem[1] = 10'd11;
    attr_mem[10] = attr(11'd100, 10'd50, 10'd1, 4'd2);
    attr_mem[11] = attr(11'd100, 10'd50, 10'd2, 4'd9);
    pat_mem[{10'd1, 4'd0}] = 16'hFFFF;
    pat_mem[{10'd2, 4'd0}] = 16'h0F0F;
    v_count = 10'd100;
    search_count = 11'd2;
    run_fetch(1000, cyc);
    checks++;
    if (cyc !== 40 || wr_cnt !== 24) begin
      errors++;
      $display("FAIL b2b_timing: cycles=%0d writes=%0d want 40 24", cyc, wr_cnt);
    end
    checks++;
    if ({lb[50], lb[54], lb[58], lb[62], lb[65]} !== 20'h29299) begin
      errors++;
      $display("FAIL b2b_overlap: got %h want 29299",
               {lb[50], lb[54], lb[58], lb[62], lb[65]});
    end
    checks++;
    if (last_wr_addr !== 10'd65) begin
      errors++;
      $display("FAIL b2b_last: got %0d want 65", last_wr_addr);
    end
    stop_fetch();
  endtask

  task automatic test_limit();
    int cyc;
    int exp_cyc;
    int exp_n;
    logic exp_ovf;
`ifdef CV_SP_FETCH_LIMIT_EN
    exp_n = 16; exp_ovf = 1'b1;
`else
    exp_n = 20; exp_ovf = 1'b0;
`endif
    exp_cyc = exp_n * 20;
    clear_logs();
    for (int i = 0; i < 20; i++) sch_mem[i] = 10'd20;
    attr_mem[20] = attr(11'd0, 10'd300, 10'd0, 4'd1);
    v_count = 10'd0;
    search_count = 11'd20;
    run_fetch(1000, cyc);
    checks++;
    if (cyc !== exp_cyc || sch_cnt !== exp_n) begin
      errors++;
      $display("FAIL limit_count: cycles=%0d sprites=%0d want %0d %0d", cyc, sch_cnt, exp_cyc, exp_n);
    end
    checks++;
    if (sp_overflow !== exp_ovf) begin
      errors++;
      $display("FAIL limit_overflow: got %b want %b", sp_overflow, exp_ovf);
    end
    stop_fetch();
    checks++;
    if (sp_overflow !== 1'b0) begin
      errors++;
      $display("FAIL limit_ovf_clear: got %b want 0", sp_overflow);
    end
  endtask

  task automatic test_abort();
    int cyc;
    int snap;
    clear_logs();
    sch_mem[0] = 10'd30;
    sch_mem[1] = 10'd31;
    attr_mem[30] = attr(11'd0, 10'd40, 10'd7, 4'd4);
    attr_mem[31] = attr(11'd0, 10'd100, 10'd6, 4'd5);
    pat_mem[{10'd7, 4'd0}] = 16'h0000;
    pat_mem[{10'd6, 4'd0}] = 16'hFFFF;
    v_count = 10'd0;
    search_count = 11'd2;
    start_fetch();
    repeat (30) tick();
    checks++;
    if (u_if.lb_wen !== 1'b1 || u_if.lb_addr !== 10'd106) begin
      errors++;
      $display("FAIL abort_px6: wen=%b addr=%0d want 1 106", u_if.lb_wen, u_if.lb_addr);
    end
    cs = 1'b0;
    tick();
    checks++;
    if (u_if.lb_wen !== 1'b0 || fetch_end !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: wen=%b fetch_end=%b want 0 0", u_if.lb_wen, fetch_end);
    end
    snap = wr_cnt;
    repeat (3) tick();
    checks++;
    if (wr_cnt !== snap || wr_cnt !== 7) begin
      errors++;
      $display("FAIL abort_writes: got %0d want 7", wr_cnt);
    end
    clear_logs();
    run_fetch(1000, cyc);
    checks++;
    if (first_sch !== 10'd0 || cyc !== 40 || wr_cnt !== 16) begin
      errors++;
      $display("FAIL abort_restart: first=%0d cycles=%0d writes=%0d want 0 40 16",
               first_sch, cyc, wr_cnt);
    end
    stop_fetch();
  endtask

  task automatic test_reset_mid_draw();
    int snap;
    clear_logs();
    sch_mem[0] = 10'd31;
    search_count = 11'd1;
    v_count = 10'd0;
    start_fetch();
    repeat (6) tick();
    checks++;
    if (u_if.lb_wen !== 1'b1) begin
      errors++;
      $display("FAIL rst_draw_pre: wen=%b want 1", u_if.lb_wen);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (u_if.lb_wen !== 1'b0 || u_if.lb_addr !== 10'd0) begin
      errors++;
      $display("FAIL rst_draw_async: wen=%b addr=%0d want 0 0", u_if.lb_wen, u_if.lb_addr);
    end
    snap = wr_cnt;
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (wr_cnt !== snap || fetch_end !== 1'b0) begin
      errors++;
      $display("FAIL rst_draw_after: writes=%0d fetch_end=%b want %0d 0", wr_cnt, fetch_end, snap);
    end
    stop_fetch();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) pat_mem[i] = 16'h0;
    for (int i = 0; i < 1024; i++) begin
      sch_mem[i]  = 10'd0;
      attr_mem[i] = 64'h0;
    end
    test_reset();
    test_zero_count();
    test_single();
    test_clip();
    test_back_to_back();
    test_limit();
    test_abort();
    test_reset_mid_draw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
